// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT stage sequencer: state encoding, error codes
// and the width helpers used to size counters from parameters.
package fft_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_RUN    = 3'd3,
    ST_GAP    = 3'd4,
    ST_DONE   = 3'd5
  } seq_state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_MISSING = 2'd1;
  localparam err_code_t ERR_LENGTH  = 2'd2;
  localparam err_code_t ERR_OP      = 2'd3;

  // Width of the idle-gap counter; GAP is limited to 0..15.
  localparam int GAP_W = 4;

  // Bits needed to hold every value 0..max_val (at least one bit).
  function automatic int bits_for(input int max_val);
    if (max_val < 2) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/seq_gap_timer.sv
// Loadable down-counter with a zero flag; times the idle gap between stages.
// It saturates at zero so it never wraps on its own, only by a reload.
module seq_gap_timer
  import fft_seq_pkg::*;
#(
  parameter int W = GAP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a reload wins over a decrement; hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != {W{1'b0}})) begin
      cnt_d = cnt_q - W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/fft_stage_sequencer.sv
// FFT stage sequencer: launches each stage of a frame on the stage counter,
// checks the returned valid/op window, spaces stages by an idle gap and
// reports frame completion or the first protocol error of the frame.
module fft_stage_sequencer
  import fft_seq_pkg::*;
#(
  parameter int STAGES    = 3,
  parameter int STAGE_LEN = 4,
  parameter int GAP       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic                         stage_vld,
  input  logic [$clog2(STAGE_LEN)-1:0] stage_op,
  output logic                         stage_start,
  output logic [$clog2(STAGES)-1:0]    stage_idx,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         err,
  output logic [1:0]                   err_code
);

  localparam int IDX_W = $clog2(STAGES);
  localparam int OP_W  = $clog2(STAGE_LEN);
  localparam int CNT_W = bits_for(STAGE_LEN);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  err_code_t        err_code_q, err_code_d;

  logic             gap_load;
  logic             gap_dec;
  logic             gap_zero;
  logic             raise;
  err_code_t        raise_code;

  seq_gap_timer #(.W(GAP_W)) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  // Next-state logic: frame acceptance, window checking and error capture.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    raise      = 1'b0;
    raise_code = ERR_NONE;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d    = ST_LAUNCH;
          idx_d      = {IDX_W{1'b0}};
          cnt_d      = {CNT_W{1'b0}};
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: begin
        // A valid arriving after the last window is an overrun, even if a
        // new frame is requested in the same cycle.
        if (stage_vld) begin
          raise      = 1'b1;
          raise_code = ERR_LENGTH;
        end else if (frame_start) begin
          state_d    = ST_LAUNCH;
          idx_d      = {IDX_W{1'b0}};
          cnt_d      = {CNT_W{1'b0}};
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        if (stage_vld) begin
          raise      = 1'b1;
          raise_code = ERR_LENGTH;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!stage_vld) begin
          raise      = 1'b1;
          raise_code = ERR_MISSING;
        end else if (stage_op != {OP_W{1'b0}}) begin
          raise      = 1'b1;
          raise_code = ERR_OP;
        end else begin
          cnt_d   = CNT_W'(1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!stage_vld) begin
          raise      = 1'b1;
          raise_code = ERR_LENGTH;
        end else if (CNT_W'(stage_op) != cnt_q) begin
          raise      = 1'b1;
          raise_code = ERR_OP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(STAGE_LEN - 1)) begin
            if (idx_q == IDX_W'(STAGES - 1)) begin
              state_d = ST_DONE;
            end else if (GAP == 0) begin
              state_d = ST_LAUNCH;
              idx_d   = idx_q + IDX_W'(1);
            end else begin
              state_d  = ST_GAP;
              gap_load = 1'b1;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_GAP: begin
        if (stage_vld) begin
          raise      = 1'b1;
          raise_code = ERR_LENGTH;
        end else if (gap_zero) begin
          state_d = ST_LAUNCH;
          idx_d   = idx_q + IDX_W'(1);
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Any error abandons the frame; the first code of a frame is kept.
    if (raise) begin
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      err_code_d = err_q ? err_code_q : raise_code;
    end else begin
      err_code_d = err_code_d;
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      idx_q      <= {IDX_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign stage_start = (state_q == ST_LAUNCH);
  assign busy        = (state_q == ST_LAUNCH) || (state_q == ST_WAIT) ||
                       (state_q == ST_RUN)    || (state_q == ST_GAP);
  assign frame_done  = (state_q == ST_DONE);
  assign stage_idx   = idx_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Self-checking bench for fft_stage_sequencer. Two instances: defaults
// (3 stages, len 4, gap 1) and a 2-stage, gap-0 variant. A frame-level model
// derives the expected stage timeline and error cycle from the frame rules.
module tb_fft_stage_sequencer;

  logic       clk;
  logic       rst;
  logic       fs_a, vld_a, fs_b, vld_b;
  logic [1:0] op_a, op_b;
  logic       ss_a, busy_a, fd_a, err_a;
  logic [1:0] idx_a, code_a;
  logic       ss_b, busy_b, fd_b, err_b;
  logic [0:0] idx_b;
  logic [1:0] code_b;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_err[2];
  int exp_code[2];

  fft_stage_sequencer #(.STAGES(3), .STAGE_LEN(4), .GAP(1)) dut_a (
    .clk(clk), .rst(rst), .frame_start(fs_a), .stage_vld(vld_a),
    .stage_op(op_a), .stage_start(ss_a), .stage_idx(idx_a), .busy(busy_a),
    .frame_done(fd_a), .err(err_a), .err_code(code_a)
  );

  fft_stage_sequencer #(.STAGES(2), .STAGE_LEN(4), .GAP(0)) dut_b (
    .clk(clk), .rst(rst), .frame_start(fs_b), .stage_vld(vld_b),
    .stage_op(op_b), .stage_start(ss_b), .stage_idx(idx_b), .busy(busy_b),
    .frame_done(fd_b), .err(err_b), .err_code(code_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input bit fsv, input bit vv, input int ov);
    fs_a = 1'b0; vld_a = 1'b0; op_a = 2'd0;
    fs_b = 1'b0; vld_b = 1'b0; op_b = 2'd0;
    if (sel == 0) begin
      fs_a = fsv; vld_a = vv; op_a = 2'(ov);
    end else begin
      fs_b = fsv; vld_b = vv; op_b = 2'(ov);
    end
  endtask

  task automatic sample(input int sel, output int ss, output int idx, output int bz,
                        output int fd, output int er, output int cd);
    if (sel == 0) begin
      ss = int'(ss_a); idx = int'(idx_a); bz = int'(busy_a);
      fd = int'(fd_a); er = int'(err_a); cd = int'(code_a);
    end else begin
      ss = int'(ss_b); idx = int'(idx_b); bz = int'(busy_b);
      fd = int'(fd_b); er = int'(err_b); cd = int'(code_b);
    end
  endtask

  // One frame on DUT 'sel'. fault: 0 none, 1 no valid after launch (stage fst),
  // 2 valid drops at window position fpos, 3 wrong op at fpos, 4 overrun
  // right after window of stage fst. poke_c: -1 random, 0 none, else cycle.
  task automatic run_frame(input int sel, input int fault, input int fst,
                           input int fpos, input int poke_c, input bit chain_in,
                           input bit chain_out, output bit chained);
    int ns, nl, ng, stride, done, e, ecode, lim, pc, last, st, pos;
    int ss, idx, bz, fd, er, cd;
    int e_ss, e_idx, e_bz, e_fd, e_er, e_cd;
    bit fsv, vv, chk_idx;
    int ov;
    string pfx;
    ns = (sel == 0) ? 3 : 2;
    nl = 4;
    ng = (sel == 0) ? 1 : 0;
    stride = nl + 1 + ng;
    done = 1 + (ns - 1) * stride + nl + 1;
    e = -1;
    ecode = 0;
    case (fault)
      1: begin e = 1 + fst * stride + 1;        ecode = 1; end
      2: begin e = 1 + fst * stride + 1 + fpos; ecode = 2; end
      3: begin e = 1 + fst * stride + 1 + fpos; ecode = 3; end
      4: begin e = 1 + fst * stride + nl + 1;   ecode = 2; end
      default: begin e = -1; ecode = 0; end
    endcase
    lim = (e >= 0) ? e + 1 : done;
    pc = poke_c;
    if (pc < 0) pc = $urandom_range(lim - 1, 1);
    chained = chain_out && (e < 0);
    last = (e >= 0) ? e + $urandom_range(3, 1) : (chained ? done : done + $urandom_range(3, 1));
    for (int c = (chain_in ? 1 : 0); c <= last; c++) begin
      @(posedge clk);
      #1;
      fsv = (c == 0) || (c == pc && c >= 1 && c < lim) || (chained && c == done);
      vv = 1'b0;
      ov = $urandom_range(3, 0);
      if ((e >= 0 && c > e) || (e < 0 && c > done)) begin
        vv = 1'($urandom_range(1, 0));
      end else if (c >= 1 && c < done) begin
        st = (c - 1) / stride;
        pos = ((c - 1) % stride) - 1;
        if (pos >= 0 && pos < nl) begin
          vv = 1'b1;
          ov = pos;
        end
        if (st == fst && pos >= 0 && pos < nl) begin
          if (fault == 1) vv = 1'b0;
          if (fault == 2 && pos >= fpos) vv = 1'b0;
          if (fault == 3 && pos == fpos) ov = (fpos + 1) % nl;
        end
        if (fault == 4 && c == e) vv = 1'b1;
      end
      drive(sel, fsv, vv, ov);
      @(negedge clk);
      sample(sel, ss, idx, bz, fd, er, cd);
      e_ss = 0; e_idx = 0; e_bz = 0; e_fd = 0; e_er = 0; e_cd = 0;
      chk_idx = 1'b0;
      if (c == 0) begin
        e_er = exp_err[sel]; e_cd = exp_code[sel];
      end else if (e >= 0 && c > e) begin
        e_er = 1; e_cd = ecode;
      end else if (c < done) begin
        e_ss = ((c - 1) % stride == 0) ? 1 : 0;
        e_bz = 1;
        e_idx = (c - 1) / stride;
        chk_idx = 1'b1;
      end else if (c == done) begin
        e_fd = 1;
        e_idx = ns - 1;
        chk_idx = 1'b1;
      end
      pfx = $sformatf("d%0d f%0d c%0d", sel, fault, c);
      check_val({pfx, " stage_start"}, ss, e_ss);
      check_val({pfx, " busy"}, bz, e_bz);
      check_val({pfx, " frame_done"}, fd, e_fd);
      check_val({pfx, " err"}, er, e_er);
      check_val({pfx, " err_code"}, cd, e_cd);
      if (chk_idx) check_val({pfx, " stage_idx"}, idx, e_idx);
    end
    exp_err[sel]  = (e >= 0) ? 1 : 0;
    exp_code[sel] = ecode;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, " a stage_start"}, int'(ss_a), 0);
    check_val({tag, " a stage_idx"}, int'(idx_a), 0);
    check_val({tag, " a busy"}, int'(busy_a), 0);
    check_val({tag, " a frame_done"}, int'(fd_a), 0);
    check_val({tag, " a err"}, int'(err_a), 0);
    check_val({tag, " a err_code"}, int'(code_a), 0);
    check_val({tag, " b busy"}, int'(busy_b), 0);
    check_val({tag, " b err"}, int'(err_b), 0);
    check_val({tag, " b err_code"}, int'(code_b), 0);
  endtask

  // Start a frame on DUT a, hit reset asynchronously in the middle of RUN.
  task automatic reset_mid_frame();
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk);
      #1;
      drive(0, (c == 0), (c >= 2), (c >= 2) ? c - 2 : 0);
    end
    #2;
    check_val("pre-reset busy", int'(busy_a), 1);
    rst = 1'b1;
    #1;
    check_all_zero("async reset");
    drive(0, 1'b0, 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_err[0] = 0; exp_code[0] = 0;
    exp_err[1] = 0; exp_code[1] = 0;
    @(negedge clk);
    check_all_zero("after reset");
  endtask

  initial begin
    bit chained;
    int sel, prev_sel, fault, fst, fpos, r, ns;
    bit prev_chained, chain_out;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 0);
    exp_err[0] = 0; exp_code[0] = 0;
    exp_err[1] = 0; exp_code[1] = 0;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // Directed frames.
    run_frame(0, 0, 0, 0, 5, 1'b0, 1'b0, chained);   // nominal, ignored poke
    run_frame(1, 0, 0, 0, 0, 1'b0, 1'b0, chained);   // two stages, no gap
    run_frame(0, 2, 1, 2, 0, 1'b0, 1'b0, chained);   // valid drops in stage 1
    run_frame(0, 3, 0, 1, 0, 1'b0, 1'b0, chained);   // op 2 where 1 expected
    run_frame(0, 1, 0, 0, 0, 1'b0, 1'b0, chained);   // no valid after launch
    run_frame(0, 0, 0, 0, 0, 1'b0, 1'b1, chained);   // clears err, chains
    run_frame(0, 0, 0, 0, 0, chained, 1'b0, chained);
    run_frame(1, 4, 0, 0, 0, 1'b0, 1'b0, chained);   // overrun into launch
    run_frame(0, 4, 1, 0, 0, 1'b0, 1'b0, chained);   // overrun into gap

    reset_mid_frame();

    // Randomized frames.
    prev_chained = 1'b0;
    prev_sel = 0;
    for (int i = 0; i < 40; i++) begin
      sel = prev_chained ? prev_sel : $urandom_range(1, 0);
      ns = (sel == 0) ? 3 : 2;
      r = $urandom_range(7, 0);
      fault = (r < 4) ? 0 : r - 3;
      fst = (fault == 4) ? $urandom_range(ns - 2, 0) : $urandom_range(ns - 1, 0);
      fpos = (fault == 2) ? $urandom_range(3, 1) : $urandom_range(3, 0);
      chain_out = (i < 39) ? 1'($urandom_range(1, 0)) : 1'b0;
      run_frame(sel, fault, fst, fpos, ($urandom_range(1, 0) == 1) ? -1 : 0,
                prev_chained, chain_out, chained);
      prev_chained = chained;
      prev_sel = sel;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
